multdiv_step_seq: RTL
=====================

Name: multdiv_step_seq

Overview:
- Parametrised multicycle step sequencer for the shared multiply/divide datapath.
- Supersedes the fixed-length divide step chain with separate programmable multiply and divide step counts, a stall, and abort/restart.
- Adds a binary step index alongside the one-hot step vector.
- Sits between decode (ctrl_MULT/ctrl_DIV pulses) and the iterative datapath, which uses step_onehot/step_idx to select per-step actions and data_resultRDY to write back.

Parameters:
- MULT_STEPS, 16: iteration steps for a multiply; legal range 1..DIV_STEPS.
- DIV_STEPS, 32: iteration steps for a divide; legal range 1..63. Also sets the one-hot vector width.
- IDX_W, 6: width of step_idx; must satisfy 2^IDX_W > DIV_STEPS.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ctrl_MULT  in  1  start multiply (sampled each rising edge)
- ctrl_DIV  in  1  start divide (sampled each rising edge)
- stall  in  1  hold the current step while high
- step_onehot  out  DIV_STEPS  bit k high during step k of the active op; zero otherwise
- step_idx  out  IDX_W  binary index of the current step; 0 when not running
- busy  out  1  high while in RUN
- op_is_div  out  1  latched operation type: 1 = divide, 0 = multiply
- data_resultRDY  out  1  one-cycle pulse on completion
- start_conflict  out  1  one-cycle pulse when both starts are sampled high together

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - step_onehot=0, step_idx=0, busy=0, op_is_div=0, data_resultRDY=0, start_conflict=0.
  - Deassertion is taken synchronously at the next clk edge.
- States: IDLE, RUN, DONE. All outputs are registered.
- Start (start = ctrl_MULT | ctrl_DIV, sampled at an edge):
  - Accepted in every state, including RUN.
  - Next cycle: state=RUN, step_idx=0, step_onehot=1, busy=1.
  - op_is_div=ctrl_DIV, and N is latched (DIV_STEPS if ctrl_DIV, else MULT_STEPS).
  - A start in RUN aborts the current op: no data_resultRDY is issued for the aborted op, and the sequence restarts at step 0 with the new op.
- Both starts high at the same edge:
  - Divide wins.
  - start_conflict pulses high for exactly the next cycle.
- RUN, no start, stall=0:
  - If step_idx < N-1: step_idx increments and step_onehot shifts left by one.
  - If step_idx == N-1: next state is DONE.
- RUN, no start, stall=1: all outputs hold. The stall length is unbounded.
- DONE (exactly one cycle):
  - data_resultRDY=1, busy=0, step_onehot=0, step_idx=0, op_is_div retains its value.
  - Next state is IDLE, or RUN if a start is sampled at this edge.
  - stall has no effect in DONE or IDLE.
- Latency with no stall: start sampled at edge 0 → step k visible in cycle k+1 → data_resultRDY high in cycle N+1.
  - Total N+1 cycles.
  - Each stalled cycle adds exactly one cycle.
- Invariants:
  - step_onehot has at most one bit set.
  - step_onehot[step_idx] == busy.
  - Bits at index ≥ N are never set.
- N=1 is legal: one RUN cycle, then DONE.
- Back-to-back ops: a start sampled in the DONE cycle gives zero idle cycles between ops.

Test Plan:
- Reset mid-RUN at step 9 of a divide → all outputs 0 immediately (no clk edge needed); after release, stays IDLE until the next start.
- ctrl_DIV pulsed one cycle, stall=0 → step_idx walks 0..31, step_onehot walks 0x1..0x8000_0000; data_resultRDY pulses in cycle 33; busy high in cycles 1..32.
- ctrl_MULT pulsed → step_idx walks 0..15; data_resultRDY in cycle 17; op_is_div=0; step_onehot bits 16..31 never set.
- Divide with stall high for 5 cycles starting at step 7 → step_idx holds at 7 for 6 cycles total; data_resultRDY moves to cycle 38.
- ctrl_MULT at step 20 of a divide → no data_resultRDY for the divide; step_idx=0 and op_is_div=0 next cycle; multiply completes 17 cycles after the restart edge.
- ctrl_MULT and ctrl_DIV high together → start_conflict=1 for one cycle; op_is_div=1; 32-step run. Then ctrl_DIV asserted in the DONE cycle → step_idx=0 in the following cycle, with no IDLE gap.

Source files
------------

// File: rtl/multdiv_step_seq.sv
// Step sequencer for the shared iterative multiply/divide datapath.
// Walks a one-hot and binary step index for MULT_STEPS or DIV_STEPS cycles, then pulses data_resultRDY.
module multdiv_step_seq #(
  parameter int MULT_STEPS = 16,
  parameter int DIV_STEPS  = 32,
  parameter int IDX_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ctrl_MULT,
  input  logic                 ctrl_DIV,
  input  logic                 stall,
  output logic [DIV_STEPS-1:0] step_onehot,
  output logic [IDX_W-1:0]     step_idx,
  output logic                 busy,
  output logic                 op_is_div,
  output logic                 data_resultRDY,
  output logic                 start_conflict,
  output logic [1:0]           state_dbg
);

  // Start/stall semantics: a start (ctrl_MULT | ctrl_DIV) is taken at any rising edge in
  // any state and always wins over stall; stall only freezes RUN and is ignored elsewhere.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]     DIV_LAST  = IDX_W'(DIV_STEPS - 1);
  localparam logic [IDX_W-1:0]     MULT_LAST = IDX_W'(MULT_STEPS - 1);
  localparam logic [DIV_STEPS-1:0] FIRST_HOT = DIV_STEPS'(1);

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic             start;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      last_idx       <= '0;
      step_onehot    <= '0;
      step_idx       <= '0;
      busy           <= 1'b0;
      op_is_div      <= 1'b0;
      data_resultRDY <= 1'b0;
      start_conflict <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      start_conflict <= 1'b0;
      if (start) begin
        // A start in RUN silently abandons the current op: no completion pulse for it.
        state          <= RUN;
        step_idx       <= '0;
        step_onehot    <= FIRST_HOT;
        busy           <= 1'b1;
        op_is_div      <= ctrl_DIV;
        last_idx       <= ctrl_DIV ? DIV_LAST : MULT_LAST;
        start_conflict <= ctrl_MULT & ctrl_DIV;
      end else begin
        case (state)
          RUN: begin
            if (!stall) begin
              if (step_idx == last_idx) begin
                state          <= DONE;
                step_idx       <= '0;
                step_onehot    <= '0;
                busy           <= 1'b0;
                data_resultRDY <= 1'b1;
              end else begin
                step_idx    <= step_idx + 1'b1;
                step_onehot <= step_onehot << 1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
